// File: rtl/fm_op_attr_bank_if.sv
// Host bus and operator pipeline read port of fm_op_attr_bank.
interface fm_op_attr_bank_if #(
  parameter int unsigned NUM_OPS = 64,
  parameter int unsigned WS_BITS = 3
);
  localparam int unsigned OPS_W = $clog2(NUM_OPS);

  logic [OPS_W:0]   addr;
  logic [31:0]      wrdata;
  logic             wren;
  logic [31:0]      rddata;
  logic [OPS_W-1:0] op_sel;
  logic             op_rd;
  logic             op_valid;
  logic [WS_BITS-1:0] op_ws;
  logic             op_am;
  logic             op_vib;
  logic             op_egt;
  logic             op_ksr;
  logic [3:0]       op_mult;
  logic [1:0]       op_ksl;
  logic [5:0]       op_tl;
  logic [3:0]       op_ar;
  logic [3:0]       op_dr;
  logic [3:0]       op_sl;
  logic [3:0]       op_rr;

  modport master (
    output addr, wrdata, wren, op_sel, op_rd,
    input  rddata, op_valid, op_ws, op_am, op_vib, op_egt, op_ksr,
           op_mult, op_ksl, op_tl, op_ar, op_dr, op_sl, op_rr
  );

  modport slave (
    input  addr, wrdata, wren, op_sel, op_rd,
    output rddata, op_valid, op_ws, op_am, op_vib, op_egt, op_ksr,
           op_mult, op_ksl, op_tl, op_ar, op_dr, op_sl, op_rr
  );
endinterface

// File: rtl/fm_op_attr_bank.sv
// Double-buffered FM operator attribute store: host shadow bank, commit-driven dirty copy into active bank.
// Define FM_OP_ATTR_INIT_EN to zero both banks in an INIT pass after reset.
module fm_op_attr_bank #(
  parameter int unsigned NUM_OPS = 64,
  parameter int unsigned WS_BITS = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  commit,
  output logic                  busy,
  fm_op_attr_bank_if.slave      bus
);
  localparam int unsigned OPS_W  = $clog2(NUM_OPS);
  localparam int unsigned ATTR_W = WS_BITS + 32;
  localparam logic [OPS_W-1:0] IDX_LAST = OPS_W'(NUM_OPS - 1);

`ifdef FM_OP_ATTR_INIT_EN
  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_INIT} state_t;
  localparam state_t ST_RESET = ST_INIT;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_SCAN} state_t;
  localparam state_t ST_RESET = ST_IDLE;
`endif

  state_t             state_q, state_d;
  logic [OPS_W-1:0]   idx_q, idx_d;
  logic               pend_q, pend_d;
  logic [NUM_OPS-1:0] dirty_q, dirty_d;
  logic [31:0]        rddata_q;
  logic [31:0]        rd_word;
  logic [ATTR_W-1:0]  op_attr_q;
  logic               op_valid_q;
  logic               copy_en;
  logic               init_we;
  logic               host_we;
  logic [OPS_W-1:0]   host_op;

  // Configuration-time contents; a runtime reset does not clear them.
  logic [ATTR_W-1:0] shadow_mem [NUM_OPS] = '{default: '0};
  logic [ATTR_W-1:0] active_mem [NUM_OPS] = '{default: '0};

  assign host_op = bus.addr[OPS_W:1];
  assign host_we = bus.wren && !init_we;
  assign busy    = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    copy_en = 1'b0;
    init_we = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (commit || pend_q) begin
          state_d = ST_SCAN;
          idx_d   = '0;
          pend_d  = 1'b0;
        end
      end
      ST_SCAN: begin
        copy_en = dirty_q[idx_q];
        idx_d   = idx_q + 1'b1;
        if (commit) pend_d = 1'b1;
        // A commit landing on the terminal index is folded into the restart.
        if (idx_q == IDX_LAST) begin
          if (pend_q || commit) pend_d = 1'b0;
          else                  state_d = ST_IDLE;
        end
      end
`ifdef FM_OP_ATTR_INIT_EN
      ST_INIT: begin
        init_we = 1'b1;
        idx_d   = idx_q + 1'b1;
        if (commit) pend_d = 1'b1;
        if (idx_q == IDX_LAST) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Set is applied after clear so a host write racing the copy keeps the operator dirty.
  always_comb begin
    dirty_d = dirty_q;
    if (copy_en) dirty_d[idx_q]   = 1'b0;
    if (host_we) dirty_d[host_op] = 1'b1;
  end

  always_comb begin
    rd_word = '0;
    if (bus.addr[0]) rd_word[WS_BITS-1:0] = shadow_mem[host_op][ATTR_W-1:32];
    else             rd_word              = shadow_mem[host_op][31:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_RESET;
      idx_q      <= '0;
      pend_q     <= 1'b0;
      dirty_q    <= '0;
      rddata_q   <= '0;
      op_attr_q  <= '0;
      op_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      dirty_q    <= dirty_d;
      rddata_q   <= rd_word;
      op_valid_q <= bus.op_rd;
      if (bus.op_rd) op_attr_q <= active_mem[bus.op_sel];
    end
  end

  // Copy reads the shadow word before this edge's host write lands.
  always_ff @(posedge clk) begin
    if (init_we) begin
      shadow_mem[idx_q] <= '0;
      active_mem[idx_q] <= '0;
    end else begin
      if (host_we) begin
        if (bus.addr[0]) shadow_mem[host_op][ATTR_W-1:32] <= bus.wrdata[WS_BITS-1:0];
        else             shadow_mem[host_op][31:0]        <= bus.wrdata;
      end
      if (copy_en) active_mem[idx_q] <= shadow_mem[idx_q];
    end
  end

  assign bus.rddata   = rddata_q;
  assign bus.op_valid = op_valid_q;
  assign bus.op_ws    = op_attr_q[ATTR_W-1:32];
  assign bus.op_am    = op_attr_q[31];
  assign bus.op_vib   = op_attr_q[30];
  assign bus.op_egt   = op_attr_q[29];
  assign bus.op_ksr   = op_attr_q[28];
  assign bus.op_mult  = op_attr_q[27:24];
  assign bus.op_ksl   = op_attr_q[23:22];
  assign bus.op_tl    = op_attr_q[21:16];
  assign bus.op_ar    = op_attr_q[15:12];
  assign bus.op_dr    = op_attr_q[11:8];
  assign bus.op_sl    = op_attr_q[7:4];
  assign bus.op_rr    = op_attr_q[3:0];
endmodule

// File: tb/tb_fm_op_attr_bank.sv
// Directed self-checking bench for fm_op_attr_bank (64x3 and 32x2 instances).
module tb_fm_op_attr_bank;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic commit64 = 1'b0, commit32 = 1'b0;
  logic busy64, busy32;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  fm_op_attr_bank_if #(.NUM_OPS(64), .WS_BITS(3)) bus64 ();
  fm_op_attr_bank_if #(.NUM_OPS(32), .WS_BITS(2)) bus32 ();

  fm_op_attr_bank #(.NUM_OPS(64), .WS_BITS(3)) dut (
    .clk(clk), .reset_n(reset_n), .commit(commit64), .busy(busy64), .bus(bus64)
  );
  fm_op_attr_bank #(.NUM_OPS(32), .WS_BITS(2)) dut32 (
    .clk(clk), .reset_n(reset_n), .commit(commit32), .busy(busy32), .bus(bus32)
  );

  function automatic logic [31:0] low64();
    return {bus64.op_am, bus64.op_vib, bus64.op_egt, bus64.op_ksr, bus64.op_mult,
            bus64.op_ksl, bus64.op_tl, bus64.op_ar, bus64.op_dr, bus64.op_sl, bus64.op_rr};
  endfunction

  task automatic host_write(input int op, input bit hi, input logic [31:0] data);
    bus64.addr = {6'(op), hi};
    bus64.wrdata = data;
    bus64.wren = 1'b1;
    @(negedge clk);
    bus64.wren = 1'b0;
  endtask

  task automatic pulse_commit();
    commit64 = 1'b1;
    @(negedge clk);
    commit64 = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    for (int c = 0; c < 400; c++) begin
      if (!busy64) break;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic pipe_read(input int op);
    bus64.op_sel = 6'(op);
    bus64.op_rd = 1'b1;
    @(negedge clk);
    bus64.op_rd = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    #3;
    n_checks++;
    if (bus64.rddata !== 32'h0 || bus64.op_valid !== 1'b0 || bus64.op_ws !== 3'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: rddata=%h op_valid=%b op_ws=%h, required 0/0/0",
               bus64.rddata, bus64.op_valid, bus64.op_ws);
    end
    @(negedge clk);
    reset_n = 1'b1;
    wait_idle(n);
`ifdef FM_OP_ATTR_INIT_EN
    n_checks++;
    if (n != 64) begin
      n_fail++;
      $display("FAIL init_busy_cycles: got %0d required 64", n);
    end
`else
    n_checks++;
    if (n != 0) begin
      n_fail++;
      $display("FAIL reset_busy: busy cycles %0d required 0", n);
    end
`endif
    repeat (40) @(negedge clk);
  endtask

  task automatic test_read_zero();
    pipe_read(17);
    n_checks++;
    if (bus64.op_valid !== 1'b1 || low64() !== 32'h0 || bus64.op_ws !== 3'h0) begin
      n_fail++;
      $display("FAIL op17_zero: valid=%b low=%h ws=%h, required 1/00000000/0",
               bus64.op_valid, low64(), bus64.op_ws);
    end
    @(negedge clk);
    n_checks++;
    if (bus64.op_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL op_valid_drop: got %b required 0", bus64.op_valid);
    end
  endtask

  task automatic test_shadow_isolation();
    host_write(5, 1'b0, 32'h12345678);
    host_write(5, 1'b1, 32'h00000007);
    pipe_read(5);
    n_checks++;
    if (low64() !== 32'h0 || bus64.op_ws !== 3'h0) begin
      n_fail++;
      $display("FAIL op5_precommit: low=%h ws=%h required 0/0", low64(), bus64.op_ws);
    end
    bus64.addr = {6'd5, 1'b0};
    @(negedge clk);
    n_checks++;
    if (bus64.rddata !== 32'h12345678) begin
      n_fail++;
      $display("FAIL readback_lo: got %h required 12345678", bus64.rddata);
    end
    bus64.addr = {6'd5, 1'b1};
    @(negedge clk);
    n_checks++;
    if (bus64.rddata !== 32'h00000007) begin
      n_fail++;
      $display("FAIL readback_hi: got %h required 00000007", bus64.rddata);
    end
  endtask

  task automatic test_commit();
    int n;
    pulse_commit();
    wait_idle(n);
    n_checks++;
    if (n != 64) begin
      n_fail++;
      $display("FAIL scan_busy_cycles: got %0d required 64", n);
    end
    pipe_read(5);
    n_checks++;
    if (bus64.op_ws !== 3'd7 || bus64.op_tl !== 6'h34 || bus64.op_ar !== 4'h5 ||
        bus64.op_rr !== 4'h8 || bus64.op_dr !== 4'h6 || bus64.op_sl !== 4'h7) begin
      n_fail++;
      $display("FAIL op5_fields: ws=%h tl=%h ar=%h dr=%h sl=%h rr=%h required 7/34/5/6/7/8",
               bus64.op_ws, bus64.op_tl, bus64.op_ar, bus64.op_dr, bus64.op_sl, bus64.op_rr);
    end
    n_checks++;
    if (bus64.op_mult !== 4'h2 || bus64.op_ksr !== 1'b1 || bus64.op_ksl !== 2'h0 ||
        bus64.op_am !== 1'b0 || bus64.op_vib !== 1'b0 || bus64.op_egt !== 1'b0) begin
      n_fail++;
      $display("FAIL op5_flags: mult=%h ksr=%b ksl=%h am=%b vib=%b egt=%b required 2/1/0/0/0/0",
               bus64.op_mult, bus64.op_ksr, bus64.op_ksl, bus64.op_am, bus64.op_vib, bus64.op_egt);
    end
    n_checks++;
    if (dut.dirty_q !== 64'h0) begin
      n_fail++;
      $display("FAIL dirty_clear: got %h required 0", dut.dirty_q);
    end
  endtask

  task automatic test_scan_collision();
    int n;
    host_write(40, 1'b0, 32'hAAAA0001);
    pulse_commit();
    repeat (40) @(negedge clk);
    host_write(40, 1'b0, 32'hBBBB0002);
    wait_idle(n);
    n_checks++;
    if (n != 23) begin
      n_fail++;
      $display("FAIL collision_tail: got %0d busy cycles required 23", n);
    end
    n_checks++;
    if (dut.dirty_q[40] !== 1'b1) begin
      n_fail++;
      $display("FAIL dirty40_kept: got %b required 1", dut.dirty_q[40]);
    end
    pipe_read(40);
    n_checks++;
    if (low64() !== 32'hAAAA0001) begin
      n_fail++;
      $display("FAIL op40_old: got %h required AAAA0001", low64());
    end
    pulse_commit();
    wait_idle(n);
    pipe_read(40);
    n_checks++;
    if (low64() !== 32'hBBBB0002 || dut.dirty_q[40] !== 1'b0) begin
      n_fail++;
      $display("FAIL op40_new: low=%h dirty=%b required BBBB0002/0", low64(), dut.dirty_q[40]);
    end
  endtask

  task automatic test_commit_overlap();
    int n;
    n = 0;
    pulse_commit();
    for (int c = 0; c < 400; c++) begin
      if (!busy64) break;
      n++;
      commit64 = (c == 10 || c == 20 || c == 30);
      @(negedge clk);
    end
    commit64 = 1'b0;
    n_checks++;
    if (n != 128) begin
      n_fail++;
      $display("FAIL overlap_busy: got %0d required 128", n);
    end
  endtask

  task automatic test_ws_mask();
    int n;
    bus32.addr = {5'd3, 1'b1};
    bus32.wrdata = 32'hFFFFFFFF;
    bus32.wren = 1'b1;
    @(negedge clk);
    bus32.wren = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus32.rddata !== 32'h00000003) begin
      n_fail++;
      $display("FAIL ws_mask_readback: got %h required 00000003", bus32.rddata);
    end
    commit32 = 1'b1;
    @(negedge clk);
    commit32 = 1'b0;
    n = 0;
    for (int c = 0; c < 200; c++) begin
      if (!busy32) break;
      n++;
      @(negedge clk);
    end
    n_checks++;
    if (n != 32) begin
      n_fail++;
      $display("FAIL scan32_busy: got %0d required 32", n);
    end
    bus32.op_sel = 5'd3;
    bus32.op_rd = 1'b1;
    @(negedge clk);
    bus32.op_rd = 1'b0;
    n_checks++;
    if (bus32.op_ws !== 2'd3 || bus32.op_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL ws_mask_commit: ws=%h valid=%b required 3/1", bus32.op_ws, bus32.op_valid);
    end
  endtask

  initial begin
    bus64.addr = '0; bus64.wrdata = '0; bus64.wren = 1'b0; bus64.op_sel = '0; bus64.op_rd = 1'b0;
    bus32.addr = '0; bus32.wrdata = '0; bus32.wren = 1'b0; bus32.op_sel = '0; bus32.op_rd = 1'b0;
    test_reset();
    test_read_zero();
    test_shadow_isolation();
    test_commit();
    test_scan_collision();
    test_commit_overlap();
    test_ws_mask();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
